// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, wait-counter width and the
// responder FSM state encoding.
package wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } wb_state_e;

endpackage

// File: rtl/wishbone_slave_regs_if.sv
// Wishbone classic-cycle bus bundle. Signal names are given from the
// responder's point of view, so the master modport drives the *_i signals.
interface wishbone_slave_regs_if;
  import wb_pkg::*;

  logic [WB_ADDR_W-1:0] adr_i;
  logic [WB_DATA_W-1:0] dat_i;
  logic                 we_i;
  logic                 cyc_i;
  logic                 stb_i;
  logic [WB_DATA_W-1:0] dat_o;
  logic                 ack_o;
  logic                 err_o;

  modport slave (
    input  adr_i, dat_i, we_i, cyc_i, stb_i,
    output dat_o, ack_o, err_o
  );

  modport master (
    output adr_i, dat_i, we_i, cyc_i, stb_i,
    input  dat_o, ack_o, err_o
  );

endinterface

// File: rtl/wishbone_regfile.sv
// NUM_REGS x 32-bit register array: one synchronous write port, one
// combinational read port, a live tap of register 0 and a synchronous clear.
module wishbone_regfile
  import wb_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     waddr_i,
  input  logic [WB_DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]     raddr_i,
  output logic [WB_DATA_W-1:0] rdata_o,
  output logic [WB_DATA_W-1:0] reg0_o
);

  logic [WB_DATA_W-1:0] regs_q [NUM_REGS];

  // Register bank: cleared on reset, one word written per enabled cycle.
  // NOTE: this array is deliberately reset because software expects every
  // register to read zero after reset; plain RAM-style storage would not be.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = regs_q[raddr_i];
  assign reg0_o  = regs_q[0];

endmodule

// File: rtl/wishbone_slave_regs.sv
// Wishbone classic-cycle responder over a small 32-bit register bank.
// Held-acknowledge handshake: one ack per transaction, held with read data
// until the initiator drops strobe. Register 0 is exported on reg0_o.
// Optional feature macro: WB_SLAVE_ERR_EN -- out-of-range accesses finish
// with err_o instead of ack_o (default build: err_o is always 0).
module wishbone_slave_regs
  import wb_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wishbone_slave_regs_if.slave  bus,
  output logic [WB_DATA_W-1:0]  reg0_o
);

  localparam int                   IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [WB_ADDR_W-1:0] SPAN      = WB_ADDR_W'(NUM_REGS * 4);
  localparam logic [WB_WAIT_W-1:0] WAIT_LOAD = WB_WAIT_W'(WAIT_STATES);

  wb_state_e            state_q, state_d;
  logic [WB_WAIT_W-1:0] cnt_q, cnt_d;
  logic [WB_ADDR_W-1:0] adr_q, adr_d;
  logic [WB_DATA_W-1:0] wdat_q, wdat_d;
  logic                 we_q, we_d;
  logic [WB_DATA_W-1:0] rdat_q, rdat_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;

  logic                 req;
  logic [WB_ADDR_W-1:0] offset;
  logic                 in_range;
  logic [IDX_W-1:0]     idx;
  logic                 wr_en;
  logic [WB_DATA_W-1:0] rd_data;

  assign req      = bus.cyc_i & bus.stb_i;
  assign offset   = adr_q - BASE_ADDR;
  assign in_range = (offset < SPAN);
  assign idx      = offset[IDX_W+1:2];

  wishbone_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_en),
    .waddr_i (idx),
    .wdata_i (wdat_q),
    .raddr_i (idx),
    .rdata_o (rd_data),
    .reg0_o  (reg0_o)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: a dropped request aborts a wait or ends the ack phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = WAIT;
      WAIT:    if (!req) state_d = IDLE;
               else if (cnt_q == '0) state_d = ACK;
      ACK:     if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic: latch the request, count wait states, and on ACK
  // entry commit the write or capture read data and pick ack or err.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    cnt_d  = cnt_q;
    adr_d  = adr_q;
    wdat_d = wdat_q;
    we_d   = we_q;
    rdat_d = rdat_q;
    ack_d  = 1'b0;
    err_d  = 1'b0;
    wr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          adr_d  = bus.adr_i;
          wdat_d = bus.dat_i;
          we_d   = bus.we_i;
          cnt_d  = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (req) begin
          if (cnt_q == '0) begin
            if (we_q) wr_en  = in_range;
            else      rdat_d = in_range ? rd_data : '0;
`ifdef WB_SLAVE_ERR_EN
            if (in_range) begin
              ack_d = 1'b1;
            end else begin
              err_d  = 1'b1;
              rdat_d = '0;
            end
`else
            ack_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ACK: begin
        if (req) begin
          ack_d = ack_q;
          err_d = err_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered bus outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      adr_q  <= '0;
      wdat_q <= '0;
      we_q   <= 1'b0;
      rdat_q <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      adr_q  <= adr_d;
      wdat_q <= wdat_d;
      we_q   <= we_d;
      rdat_q <= rdat_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
    end
  end

  assign bus.dat_o = rdat_q;
  assign bus.ack_o = ack_q;
  assign bus.err_o = err_q;

endmodule
